// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB master arbiter and its round-robin picker.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_AW_DEFAULT = 32;
    localparam int APB_DW_DEFAULT = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr wins.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan N candidates starting at ptr; the first hit locks out the rest.
    always_comb begin
        int   cand;
        logic hit;
        cand  = 0;
        hit   = 1'b0;
        grant = {N{1'b0}};
        idx   = {IW{1'b0}};
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand        = (int'(ptr) + i) % N;
            hit         = req[cand] & ~valid;
            grant[cand] = grant[cand] | hit;
            idx         = hit ? IW'(cand) : idx;
            valid       = valid | hit;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NREQ requesters: round-robin grant,
// SETUP/ACCESS sequencing, ACCESS timeout and a one-cycle registered response.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = APB_AW_DEFAULT,
    parameter int DW      = APB_DW_DEFAULT,
    parameter int TIMEOUT = 16
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic [DW-1:0]      prdata,
    input  logic               pready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    apb_state_e      state_r;
    apb_state_e      next_state_s;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   idx_r;
    logic [CW-1:0]   cnt_r;
    logic            psel_r;
    logic            penable_r;
    logic            pwrite_r;
    logic [AW-1:0]   paddr_r;
    logic [DW-1:0]   pwdata_r;
    logic [NREQ-1:0] ack_r;
    logic [DW-1:0]   rdata_r;
    logic            err_r;

    logic [NREQ-1:0] eligible_s;
    logic [NREQ-1:0] grant_s;
    logic [IW-1:0]   grant_idx_s;
    logic            grant_valid_s;
    logic            sel_write_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_wdata_s;
    logic            done_s;
    logic            timeout_s;

    // A requester being acked this cycle still shows its old req; mask it out.
    assign eligible_s = req & ~ack_r;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .req   (eligible_s),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (grant_idx_s),
        .valid (grant_valid_s)
    );

    // Mux the winning requester's transfer fields.
    always_comb begin
        sel_write_s = |(req_write & grant_s);
        sel_addr_s  = req_addr[int'(grant_idx_s) * AW +: AW];
        sel_wdata_s = req_wdata[int'(grant_idx_s) * DW +: DW];
    end

    // Next-state decode; done_s marks the edge that ends a transfer.
    always_comb begin
        next_state_s = state_r;
        done_s       = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    next_state_s = ST_SETUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                next_state_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    done_s       = 1'b1;
                    next_state_s = ST_IDLE;
                end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                    done_s       = 1'b1;
                    timeout_s    = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, bus outputs, request latch, timeout counter and response registers.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {IW{1'b0}};
            idx_r     <= {IW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {AW{1'b0}};
            pwdata_r  <= {DW{1'b0}};
            ack_r     <= {NREQ{1'b0}};
            rdata_r   <= {DW{1'b0}};
            err_r     <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            psel_r    <= (next_state_s != ST_IDLE);
            penable_r <= (next_state_s == ST_ACCESS);

            if (state_r == ST_IDLE && grant_valid_s) begin
                idx_r    <= grant_idx_s;
                pwrite_r <= sel_write_s;
                paddr_r  <= sel_addr_s;
                pwdata_r <= sel_wdata_s;
            end

            if (state_r == ST_ACCESS && !done_s) begin
                cnt_r <= cnt_r + CW'(1'b1);
            end else begin
                cnt_r <= {CW{1'b0}};
            end

            // Response is a single-cycle pulse; rdata is zero for writes and aborts.
            if (done_s) begin
                ack_r   <= {{(NREQ-1){1'b0}}, 1'b1} << idx_r;
                rdata_r <= (pready && !pwrite_r) ? prdata : {DW{1'b0}};
                err_r   <= timeout_s;
                ptr_r   <= (idx_r == IW'(NREQ - 1)) ? {IW{1'b0}} : idx_r + IW'(1'b1);
            end else begin
                ack_r   <= {NREQ{1'b0}};
                rdata_r <= {DW{1'b0}};
                err_r   <= 1'b0;
            end
        end
    end

    assign psel      = psel_r;
    assign penable   = penable_r;
    assign pwrite    = pwrite_r;
    assign paddr     = paddr_r;
    assign pwdata    = pwdata_r;
    assign ack       = ack_r;
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: stimulus queues expected bus and
// response records, independent monitors pop and compare them.
module tb_apb_master_arbiter;

    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  req;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  ack;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    apb_master_arbiter #(
        .NREQ    (2),
        .AW      (32),
        .DW      (32),
        .TIMEOUT (16)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [1:0]  ack;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } bus_t;

    rsp_t exp_rsp[$];
    bus_t exp_bus[$];

    int errors = 0;
    int checks = 0;
    int psel_cnt = 0;
    int penable_cnt = 0;

    int          slv_wait = 1;
    logic        slv_hang = 1'b0;
    logic [31:0] slv_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic [31:0] a, input logic w, input logic [31:0] d);
        bus_t b;
        b.addr = a; b.write = w; b.wdata = d;
        exp_bus.push_back(b);
    endtask

    task automatic push_rsp(input logic [1:0] a, input logic [31:0] d, input logic e);
        rsp_t r;
        r.ack = a; r.rdata = d; r.err = e;
        exp_rsp.push_back(r);
    endtask

    // n = number of clock edges until ack shows; limit+1 on expiry
    task automatic wait_ack(input int limit, output int n);
        n = 0;
        while (n <= limit) begin
            @(negedge pclk);
            if (ack !== 2'b00) break;
            n++;
        end
    endtask

    task automatic wait_penable(input int limit, output int n);
        n = 0;
        while (n <= limit) begin
            @(negedge pclk);
            if (penable === 1'b1) break;
            n++;
        end
    endtask

    // APB slave: pready in the ACCESS cycle numbered slv_wait unless hung
    initial begin
        int acc;
        acc = 0;
        pready = 1'b0;
        prdata = 32'h0;
        forever begin
            @(posedge pclk);
            #1;
            if (psel && penable) begin
                pready = !slv_hang && (acc == slv_wait);
                acc++;
            end else begin
                pready = 1'b0;
                acc = 0;
            end
            prdata = slv_rdata;
        end
    end

    // Activity counters
    initial begin
        forever begin
            @(negedge pclk);
            if (psel === 1'b1) psel_cnt++;
            if (penable === 1'b1) penable_cnt++;
        end
    end

    // Response monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge pclk);
            if (!preset && ack !== 2'b00) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_ack", 32'(ack), 32'(r.ack));
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    chk("ack_psel_low", 32'(psel), 32'h0);
                end
            end
        end
    end

    // Bus monitor: SETUP cycles pop the expected transfer; ACCESS holds paddr
    initial begin
        bus_t b;
        logic [31:0] cur_addr;
        cur_addr = 32'h0;
        forever begin
            @(negedge pclk);
            if (!preset && psel === 1'b1 && penable === 1'b0) begin
                if (exp_bus.size() == 0) begin
                    chk("unexpected_setup", paddr, 32'hFFFF_FFFF);
                end else begin
                    b = exp_bus.pop_front();
                    cur_addr = b.addr;
                    chk("setup_paddr", paddr, b.addr);
                    chk("setup_pwrite", 32'(pwrite), 32'(b.write));
                    if (b.write) chk("setup_pwdata", pwdata, b.wdata);
                end
            end else if (!preset && psel === 1'b1 && penable === 1'b1) begin
                chk("access_paddr_hold", paddr, cur_addr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        int c0;
        int c1;
        preset    = 1'b1;
        req       = 2'b00;
        req_write = 2'b00;
        req_addr  = 64'h0;
        req_wdata = 64'h0;
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_psel", 32'(psel), 32'h0);
        chk("rst_penable", 32'(penable), 32'h0);
        chk("rst_pwrite", 32'(pwrite), 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'h0);
        preset = 1'b0;

        // Single one-wait read from requester 0
        @(posedge pclk); #1;
        slv_wait = 1; slv_rdata = 32'h0000_000A;
        req_addr[31:0] = 32'h0; req_write[0] = 1'b0;
        push_bus(32'h0, 1'b0, 32'h0);
        push_rsp(2'b01, 32'h0000_000A, 1'b0);
        p0 = psel_cnt;
        req[0] = 1'b1;
        wait_ack(20, n);
        chk("read_latency", 32'(n), 32'd4);
        chk("read_psel_cycles", 32'(psel_cnt - p0), 32'd3);
        @(posedge pclk); #1;
        req[0] = 1'b0;
        repeat (2) @(posedge pclk);

        // Reset during ACCESS: pointer is 1 here and must return to 0
        #1;
        slv_hang = 1'b1;
        req_addr[31:0] = 32'h40;
        push_bus(32'h40, 1'b0, 32'h0);
        req[0] = 1'b1;
        wait_penable(10, n);
        chk("rst_reach_access", 32'(penable), 32'h1);
        @(posedge pclk); #1;
        preset = 1'b1;
        #1;
        chk("async_rst_psel", 32'(psel), 32'h0);
        chk("async_rst_penable", 32'(penable), 32'h0);
        chk("async_rst_ack", 32'(ack), 32'h0);
        req[0] = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        slv_hang = 1'b0;
        p0 = psel_cnt;
        repeat (3) @(posedge pclk);
        chk("rst_no_reissue", 32'(psel_cnt - p0), 32'h0);
        #1;

        // Both requesters continuously: alternating zero-wait writes 0,1,0,1
        slv_wait = 0;
        req_write = 2'b11;
        req_addr  = {32'h14, 32'h10};
        req_wdata = {32'h3, 32'h5};
        push_bus(32'h10, 1'b1, 32'h5); push_rsp(2'b01, 32'h0, 1'b0);
        push_bus(32'h14, 1'b1, 32'h3); push_rsp(2'b10, 32'h0, 1'b0);
        push_bus(32'h10, 1'b1, 32'h5); push_rsp(2'b01, 32'h0, 1'b0);
        push_bus(32'h14, 1'b1, 32'h3); push_rsp(2'b10, 32'h0, 1'b0);
        req = 2'b11;
        c0 = 0; c1 = 0; n = 0;
        while (!(c0 == 2 && c1 == 2) && n < 60) begin
            @(negedge pclk);
            n++;
            if (ack[0] === 1'b1) c0++;
            if (ack[1] === 1'b1) c1++;
            if (c0 == 2) req[0] = 1'b0;
            if (c1 == 2) req[1] = 1'b0;
        end
        chk("alt_acks0", 32'(c0), 32'd2);
        chk("alt_acks1", 32'(c1), 32'd2);
        req = 2'b00;
        @(posedge pclk); #1;

        // Slave never ready: abort after 16 ACCESS cycles with err and zero data
        req_write = 2'b00;
        slv_hang = 1'b1; slv_rdata = 32'hDEAD_BEEF;
        req_addr[31:0] = 32'h20;
        push_bus(32'h20, 1'b0, 32'h0);
        push_rsp(2'b01, 32'h0, 1'b1);
        p0 = penable_cnt;
        req[0] = 1'b1;
        wait_ack(40, n);
        chk("timeout_latency", 32'(n), 32'd18);
        chk("timeout_access_cycles", 32'(penable_cnt - p0), 32'd16);
        @(posedge pclk); #1;
        req[0] = 1'b0;
        slv_hang = 1'b0; slv_wait = 0; slv_rdata = 32'h1234_5678;
        req_addr[63:32] = 32'h24;
        push_bus(32'h24, 1'b0, 32'h0);
        push_rsp(2'b10, 32'h1234_5678, 1'b0);
        req[1] = 1'b1;
        wait_ack(20, n);
        chk("post_timeout_latency", 32'(n), 32'd3);
        @(posedge pclk); #1;
        req[1] = 1'b0;
        @(posedge pclk); #1;

        // Stale req during the ack cycle must not start a duplicate transfer
        slv_rdata = 32'h77;
        req_addr[63:32] = 32'h30;
        push_bus(32'h30, 1'b0, 32'h0);
        push_rsp(2'b10, 32'h77, 1'b0);
        req[1] = 1'b1;
        wait_ack(20, n);
        p0 = psel_cnt;
        @(posedge pclk); #1;
        req[1] = 1'b0;
        repeat (4) @(negedge pclk);
        chk("stale_req_no_dup", 32'(psel_cnt - p0), 32'h0);
        @(posedge pclk); #1;

        // req still high after the ack cycle: a second transfer follows
        push_bus(32'h30, 1'b0, 32'h0); push_rsp(2'b10, 32'h77, 1'b0);
        push_bus(32'h30, 1'b0, 32'h0); push_rsp(2'b10, 32'h77, 1'b0);
        req[1] = 1'b1;
        wait_ack(20, n);
        wait_ack(20, n);
        chk("repeat_req_latency", 32'(n), 32'd3);
        @(posedge pclk); #1;
        req[1] = 1'b0;
        @(posedge pclk); #1;

        // Address changes during ACCESS; bus keeps the latched 0x4
        slv_wait = 1; slv_rdata = 32'hC;
        req_addr[31:0] = 32'h4;
        push_bus(32'h4, 1'b0, 32'h0);
        push_rsp(2'b01, 32'hC, 1'b0);
        req[0] = 1'b1;
        wait_penable(10, n);
        req_addr[31:0] = 32'h8;
        @(negedge pclk);
        chk("addr_change_paddr", paddr, 32'h4);
        wait_ack(20, n);
        chk("addr_change_ack_seen", 32'(ack), 32'h1);
        @(posedge pclk); #1;
        req[0] = 1'b0;
        repeat (3) @(posedge pclk);

        chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'h0);
        chk("bus_queue_drained", 32'(exp_bus.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB master port between `NREQ` on-chip requesters, such as the CPU bus bridge and a DMA engine, that target APB peripherals like the GPIO block. It arbitrates round-robin and sequences the APB SETUP/ACCESS phases. It returns read data and completion to the winning requester, and aborts any transfer whose slave never raises `pready`.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 16: maximum ACCESS cycles before abort (≥2).

Ports:
- `pclk`  in  1  single clock for the whole block.
- `preset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester transfer request, held until that requester's `ack`.
- `req_write`  in  NREQ  1 = write, 0 = read.
- `req_addr`  in  NREQ*AW  packed addresses; requester i at `[i*AW +: AW]`.
- `req_wdata`  in  NREQ*DW  packed write data.
- `ack`  out  NREQ  one-cycle completion pulse, one-hot.
- `rsp_rdata`  out  DW  read data, valid while `ack` is high.
- `rsp_err`  out  1  timeout flag, valid while `ack` is high.
- `psel`, `penable`, `pwrite`  out  1  APB master controls.
- `paddr`  out  AW  APB address.
- `pwdata`  out  DW  APB write data.
- `prdata`  in  DW  APB read data.
- `pready`  in  1  APB ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any eligible `req` bit is set, pick the winner round-robin, starting at the index after the last granted requester.
  - Latch the winner's index, write flag, address and wdata.
  - Next state is SETUP.
- A requester is not eligible during the cycle its own `ack` is high. This blocks the stale `req` that is still high in that cycle.
- SETUP: `psel`=1, `penable`=0, APB address/data/write driven from the latched values. `pready` is ignored. Next state is ACCESS, unconditionally.
- ACCESS:
  - `psel`=1 and `penable`=1; the timeout counter increments each cycle.
  - `pready`=1 sampled: latch `prdata` (forced to 0 for writes) and go to IDLE.
  - Counter reaches `TIMEOUT`: set the error flag, force rdata to 0 and go to IDLE.
- Completion: `ack[idx]`, `rsp_rdata` and `rsp_err` are registered and high for exactly the one IDLE cycle after the transfer. The round-robin pointer advances to `idx+1` (mod `NREQ`) at the same edge.
- The latched request is immutable. A requester dropping or changing `req` mid-transfer does not affect the bus cycle in flight.
- Every transfer includes at least one IDLE cycle with `psel`=0. This covers slaves whose `pready` stays high for one extra cycle.
- Simultaneous requests: exactly one grant per IDLE decision; the others wait. Worst-case wait is (`NREQ`-1) transfers.

## Timing
- Reset values: state IDLE, `psel`/`penable`/`pwrite`=0, `paddr`/`pwdata`=0, `ack`=0, `rsp_rdata`=0, `rsp_err`=0, round-robin pointer 0, counter 0.
- Reset asserted mid-transfer:
  - All outputs go to their reset values immediately, with no clock needed.
  - The transfer is dropped with no `ack`; the requester re-issues it.
- `req` high before edge 0 → SETUP from edge 0 → ACCESS from edge 1.
- A zero-wait slave (`pready` high at edge 2) gives `ack` high in cycle 2–3 (after edge 2). A one-wait slave such as the GPIO block (`pready` registered) gives `ack` after edge 3.
- Throughput: one transfer per 4 cycles with zero-wait slaves (IDLE, SETUP, ACCESS, ack/IDLE).
- Timeout: `ack` with `rsp_err`=1 follows `TIMEOUT` ACCESS cycles; the counter width is $clog2(TIMEOUT+1).

## Structure
- Shared package `apb_arb_pkg`: state enum (IDLE/SETUP/ACCESS) and default `AW`/`DW` constants.
- Sub-module `rr_arbiter`: combinational round-robin picker.
  - Inputs: `req & eligible`, pointer.
  - Outputs: one-hot grant, binary index, valid.
  - Reusable by other shared-resource controllers.
- The top level holds the FSM, request latches, timeout counter and response registers.

## Test plan
- Single read, requester 0, `addr=0x0`, slave returns `prdata=0x0000_000A` with one wait state → `ack=01` one cycle after `pready`, `rsp_rdata=0xA`, `rsp_err=0`. `psel` is high for exactly 3 cycles.
- Requesters 0 and 1 both request continuously, alternating writes of `0x5`/`0x3` → grants alternate 0,1,0,1, `psel` drops for ≥1 cycle between transfers, and each `pwdata` matches its requester.
- Slave holds `pready`=0, `TIMEOUT`=16 → `ack` after 16 ACCESS cycles, `rsp_err`=1, `rsp_rdata=0`, and the next request proceeds normally.
- `preset` pulsed during ACCESS → `psel`/`penable` go low asynchronously, no `ack` is issued, and the pointer returns to 0.
- Requester 1 keeps `req` high during its `ack` cycle with requester 0 idle → no duplicate transfer on that cycle. A new transfer starts only if `req` is still high after the ack cycle.
- Requester changes `req_addr` from 0x4 to 0x8 in ACCESS → `paddr` stays 0x4 until completion.
